// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Initiator side of the CSR port. Executes one Zicsr instruction per request:
//   reads the CSR, computes the read-modify-write value, writes it back when
//   the instruction asks for a write, then returns the old value for rd.
//
// Ports
//   clock, reset              single rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_funct3/addr/rs1_idx/  instruction fields and rs1 value
//   req_rs1_val/req_rd_idx
//   resp_valid/resp_ready     response handshake
//   resp_rdata/resp_rd_idx/   old CSR value, destination index, illegal flag
//   resp_illegal
//   inst_ret                  retire pulse in the response handshake cycle
//   csr_wen/addr/wdata        CSR file write/address port
//   csr_rdata                 CSR file read data, combinational from csr_addr

module csr_access_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [11:0]     req_addr,
   input  logic [4:0]      req_rs1_idx,
   input  logic [XLEN-1:0] req_rs1_val,
   input  logic [4:0]      req_rd_idx,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic [4:0]      resp_rd_idx,
   output logic            resp_illegal,
   output logic            inst_ret,
   output logic            csr_wen,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   input  logic [XLEN-1:0] csr_rdata
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRead  = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [11:0]     addr_q, addr_d;
   logic [4:0]      rs1_idx_q, rs1_idx_d;
   logic [XLEN-1:0] rs1_val_q, rs1_val_d;
   logic [4:0]      rd_idx_q, rd_idx_d;
   logic [XLEN-1:0] old_q, old_d;
   logic            wen_q, wen_d;
   logic            illegal_q, illegal_d;

   logic            acc_wen;
   logic            acc_illegal;
   logic [XLEN-1:0] src;
   logic [XLEN-1:0] new_val;

   // Decode of the incoming request. RW/RWI always write; the set/clear forms
   // write only when the rs1/zimm field is non-zero.
   always_comb begin
      acc_wen     = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
      acc_illegal = (req_funct3[1:0] == 2'b00) ||
                    (acc_wen && (req_addr[11:10] == 2'b11));
   end

   // Immediate forms use the rs1 field as a zero-extended 5-bit zimm.
   always_comb begin
      src = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
      unique case (funct3_q[1:0])
         2'b01:   new_val = src;
         2'b10:   new_val = old_q | src;
         default: new_val = old_q & ~src;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      funct3_d  = funct3_q;
      addr_d    = addr_q;
      rs1_idx_d = rs1_idx_q;
      rs1_val_d = rs1_val_q;
      rd_idx_d  = rd_idx_q;
      old_d     = old_q;
      wen_d     = wen_q;
      illegal_d = illegal_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               funct3_d  = req_funct3;
               addr_d    = req_addr;
               rs1_idx_d = req_rs1_idx;
               rs1_val_d = req_rs1_val;
               rd_idx_d  = req_rd_idx;
               old_d     = '0;
               wen_d     = acc_wen && !acc_illegal;
               illegal_d = acc_illegal;
               state_d   = acc_illegal ? StResp : StRead;
            end
         end
         StRead: begin
            old_d   = csr_rdata;
            state_d = wen_q ? StWrite : StResp;
         end
         StWrite: begin
            state_d = StResp;
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         funct3_q  <= '0;
         addr_q    <= '0;
         rs1_idx_q <= '0;
         rs1_val_q <= '0;
         rd_idx_q  <= '0;
         old_q     <= '0;
         wen_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         rs1_idx_q <= rs1_idx_d;
         rs1_val_q <= rs1_val_d;
         rd_idx_q  <= rd_idx_d;
         old_q     <= old_d;
         wen_q     <= wen_d;
         illegal_q <= illegal_d;
      end
   end

   // Outputs are decoded from state so a reset clears them immediately.
   always_comb begin
      req_ready    = (state_q == StIdle);
      resp_valid   = (state_q == StResp);
      resp_rdata   = resp_valid ? old_q : '0;
      resp_rd_idx  = resp_valid ? rd_idx_q : 5'd0;
      resp_illegal = resp_valid && illegal_q;
      inst_ret     = resp_valid && resp_ready && !illegal_q;
      csr_wen      = (state_q == StWrite);
      csr_addr     = ((state_q == StRead) || (state_q == StWrite)) ? addr_q : 12'd0;
      csr_wdata    = csr_wen ? new_val : '0;
   end

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [11:0] req_addr;
   logic [4:0]  req_rs1_idx;
   logic [31:0] req_rs1_val;
   logic [4:0]  req_rd_idx;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd_idx;
   logic        resp_illegal;
   logic        inst_ret;
   logic        csr_wen;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;

   csr_access_unit #(.XLEN(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_rs1_idx  (req_rs1_idx),
      .req_rs1_val  (req_rs1_val),
      .req_rd_idx   (req_rd_idx),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_rd_idx  (resp_rd_idx),
      .resp_illegal (resp_illegal),
      .inst_ret     (inst_ret),
      .csr_wen      (csr_wen),
      .csr_addr     (csr_addr),
      .csr_wdata    (csr_wdata),
      .csr_rdata    (csr_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // CSR file seen by the DUT, and the bench's own reference copy.
   logic [31:0] csr_mem [0:4095];
   logic [31:0] ref_mem [0:4095];

   assign csr_rdata = csr_mem[csr_addr];
   always @(posedge clock) if (csr_wen) csr_mem[csr_addr] = csr_wdata;

   typedef struct {
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        ill;
      logic        we;
      logic [31:0] wdata;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one instruction from a falling edge, follow it to the response,
   // stall the response for 'hold' cycles, then complete the handshake.
   task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1i,
                         input logic [31:0] rs1v, input logic [4:0] rdi, input int hold);
      exp_t        e;
      exp_t        g;
      logic [31:0] src;
      logic [31:0] old;
      logic [31:0] nv;
      logic        we;
      logic        ill;
      int          lat;
      int          wen_cnt;
      logic [31:0] wd_seen;

      old = ref_mem[a];
      src = f3[2] ? {27'b0, rs1i} : rs1v;
      we  = (f3[1:0] == 2'b01) || (rs1i != 5'd0);
      ill = (f3[1:0] == 2'b00) || (we && (a[11:10] == 2'b11));
      case (f3[1:0])
         2'b01:   nv = src;
         2'b10:   nv = old | src;
         default: nv = old & ~src;
      endcase
      e.rdata = ill ? 32'd0 : old;
      e.rd    = rdi;
      e.ill   = ill;
      e.we    = we && !ill;
      e.wdata = nv;
      e.lat   = ill ? 1 : (we ? 3 : 2);
      if (e.we) ref_mem[a] = nv;

      check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid   = 1'b1;
      req_funct3  = f3;
      req_addr    = a;
      req_rs1_idx = rs1i;
      req_rs1_val = rs1v;
      req_rd_idx  = rdi;
      @(posedge clock);
      sb_q.push_back(e);
      @(negedge clock);
      req_valid = 1'b0;

      lat     = 0;
      wen_cnt = 0;
      wd_seen = 32'd0;
      for (int i = 0; i < 20; i++) begin
         lat++;
         if (lat == 1 && !e.ill) check_eq("read_addr", {20'd0, csr_addr}, {20'd0, a});
         if (csr_wen) begin
            wen_cnt++;
            wd_seen = csr_wdata;
            check_eq("write_addr", {20'd0, csr_addr}, {20'd0, a});
         end
         if (resp_valid) break;
         @(negedge clock);
      end

      g = sb_q.pop_front();
      check_eq("resp_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("latency", lat, g.lat);
      check_eq("wen_count", wen_cnt, g.we ? 32'd1 : 32'd0);
      if (g.we) check_eq("wdata", wd_seen, g.wdata);
      check_eq("resp_rdata", resp_rdata, g.rdata);
      check_eq("resp_rd_idx", {27'd0, resp_rd_idx}, {27'd0, g.rd});
      check_eq("resp_illegal", {31'd0, resp_illegal}, {31'd0, g.ill});
      check_eq("resp_csr_addr", {20'd0, csr_addr}, 32'd0);

      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check_eq("hold_valid", {31'd0, resp_valid}, 32'd1);
         check_eq("hold_rdata", resp_rdata, g.rdata);
         check_eq("hold_ready", {31'd0, req_ready}, 32'd0);
         check_eq("hold_ret", {31'd0, inst_ret}, 32'd0);
      end

      resp_ready = 1'b1;
      #1;
      check_eq("inst_ret", {31'd0, inst_ret}, {31'd0, !g.ill});
      check_eq("hs_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clock);
      resp_ready = 1'b0;
      check_eq("post_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("post_ret", {31'd0, inst_ret}, 32'd0);
   endtask

   logic [11:0] addrs [6];

   initial begin
      addrs = '{12'hB00, 12'hB02, 12'h340, 12'hC00, 12'hF11, 12'h301};
      for (int i = 0; i < 4096; i++) csr_mem[i] = 32'(i) ^ 32'h5A5A_0000;
      csr_mem[12'hB00] = 32'h1234_5678;
      csr_mem[12'h301] = 32'h4000_1000;
      csr_mem[12'hB02] = 32'h0000_000F;
      csr_mem[12'hF11] = 32'hABCD_0001;
      for (int i = 0; i < 4096; i++) ref_mem[i] = csr_mem[i];

      reset       = 1'b1;
      req_valid   = 1'b0;
      req_funct3  = 3'd0;
      req_addr    = 12'd0;
      req_rs1_idx = 5'd0;
      req_rs1_val = 32'd0;
      req_rd_idx  = 5'd0;
      resp_ready  = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_wen", {31'd0, csr_wen}, 32'd0);
      check_eq("rst_addr", {20'd0, csr_addr}, 32'd0);
      check_eq("rst_rdata", resp_rdata, 32'd0);
      check_eq("rst_ret", {31'd0, inst_ret}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      do_req(3'b001, 12'hB00, 5'd5, 32'h10, 5'd3, 0);        // RW
      do_req(3'b010, 12'h301, 5'd0, 32'hFFFF, 5'd4, 0);      // RS, no write
      do_req(3'b001, 12'hF11, 5'd1, 32'h1, 5'd6, 0);         // RW to read-only: illegal
      do_req(3'b111, 12'hB02, 5'd3, 32'h0, 5'd7, 0);         // RCI 0x0F -> 0x0C
      do_req(3'b110, 12'hB02, 5'd0, 32'hFF, 5'd8, 0);        // RSI zimm=0, no write
      do_req(3'b010, 12'h340, 5'd7, 32'hF0, 5'd9, 5);        // RS with stalled response
      do_req(3'b000, 12'h340, 5'd1, 32'h1, 5'd1, 1);         // reserved funct3
      do_req(3'b100, 12'h340, 5'd1, 32'h1, 5'd1, 0);         // reserved funct3
      do_req(3'b011, 12'hC00, 5'd0, 32'hFF, 5'd2, 0);        // read-only, write suppressed
      do_req(3'b110, 12'hC00, 5'd2, 32'h0, 5'd2, 0);         // RSI to read-only: illegal
      do_req(3'b101, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd0, 0); // RWI zimm=0 still writes

      for (int n = 0; n < 24; n++) begin
         do_req(3'($urandom_range(7)), addrs[$urandom_range(5)], 5'($urandom_range(3)),
                $urandom, 5'($urandom_range(31)), $urandom_range(2));
      end

      // Reset while in WRITE: the write must be dropped.
      req_valid   = 1'b1;
      req_funct3  = 3'b001;
      req_addr    = 12'hB00;
      req_rs1_idx = 5'd1;
      req_rs1_val = 32'hDEAD_BEEF;
      req_rd_idx  = 5'd1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      check_eq("pre_rst_wen", {31'd0, csr_wen}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("async_wen", {31'd0, csr_wen}, 32'd0);
      check_eq("async_addr", {20'd0, csr_addr}, 32'd0);
      check_eq("async_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("async_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("rel_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rel_valid", {31'd0, resp_valid}, 32'd0);
      do_req(3'b010, 12'hB00, 5'd0, 32'h0, 5'd11, 0);        // old value must be intact

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
